// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-master arbiter and access sequencer for a single-port
//            32x32 synchronous RAM. Each transaction takes IDLE -> ACCESS ->
//            RESP (3 cycles). Read data is returned registered to the
//            master that won the transaction.
// Ports    : clk, reset_n (async, active-low)
//            m0_/m1_ req, wr, addr, wdata     - master request side
//            m0_/m1_ grant, rvalid, rdata     - master response side
//            busy                             - high whenever not IDLE
//            S_cen, S_wen, S_addr, S_din      - RAM pins (registered)
//            S_dout                           - RAM read data
// Config   : ARB_FIXED_PRIO_EN - when defined, m0 always beats m1 and no
//            last-winner state exists; otherwise round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_grant,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m1_grant,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              busy,
  output logic              S_cen,
  output logic              S_wen,
  output logic [ADDR_W-1:0] S_addr,
  output logic [DATA_W-1:0] S_din,
  input  logic [DATA_W-1:0] S_dout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_sel;      // winner of the transaction in flight (1 = m1)
  logic                r_is_read;  // S_wen is cleared at E1, so remember the op here
  logic [1:0]          r_grant;
  logic [1:0]          r_rvalid;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_busy;
  logic                r_cen;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;

  logic                w_any_req;
  logic                w_win;      // 1 = m1 wins this edge
  logic                w_accept;
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  assign w_any_req = m0_req | m1_req;
  assign w_accept  = (r_state == ST_IDLE) && w_any_req;

`ifdef ARB_FIXED_PRIO_EN
  // m1 only wins when m0 is silent.
  assign w_win = ~m0_req;
`else
  logic r_last_winner;

  // On a tie the master that did not win last time takes this one.
  always_comb begin
    w_win = m1_req;
    if (m0_req && m1_req) begin
      w_win = ~r_last_winner;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_winner <= 1'b1;  // m1, so m0 wins the first tie
    end else if (w_accept) begin
      r_last_winner <= w_win;
    end
  end
`endif

  assign w_sel_wr    = w_win ? m1_wr    : m0_wr;
  assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_sel     <= 1'b0;
      r_is_read <= 1'b0;
      r_grant   <= 2'b00;
      r_rvalid  <= 2'b00;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_busy    <= 1'b0;
      r_cen     <= 1'b0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
    end else begin
      // grant and rvalid are single-cycle pulses
      r_grant  <= 2'b00;
      r_rvalid <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          r_cen <= 1'b0;
          if (w_any_req) begin
            r_sel          <= w_win;
            r_is_read      <= ~w_sel_wr;
            r_cen          <= 1'b1;
            r_wen          <= w_sel_wr;
            r_addr         <= w_sel_addr;
            r_din          <= w_sel_wdata;
            r_grant[w_win] <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // RAM samples its pins at this edge; address/data simply hold.
          r_cen   <= 1'b0;
          r_wen   <= 1'b0;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (r_is_read) begin
            if (r_sel) begin
              r_rdata1 <= S_dout;
            end else begin
              r_rdata0 <= S_dout;
            end
            r_rvalid[r_sel] <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cen   <= 1'b0;
          r_wen   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_grant  = r_grant[0];
  assign m1_grant  = r_grant[1];
  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign busy      = r_busy;
  assign S_cen     = r_cen;
  assign S_wen     = r_wen;
  assign S_addr    = r_addr;
  assign S_din     = r_din;

endmodule
`default_nettype wire
